// File: rtl/onehot_dec_seq.sv
// onehot_dec_seq: registered binary-to-one-hot decoder with load, up/down scan and blank modes
module onehot_dec_seq #(
  parameter int SEL_W = 3,
  parameter int N_OUT = 8,
  parameter int PRE_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [SEL_W-1:0] sel,
  input  logic [PRE_W-1:0] prescale,
  output logic [N_OUT-1:0] out,
  output logic [SEL_W-1:0] idx,
  output logic             wrap,
  output logic             err
);
  typedef enum logic [1:0] {DEC, SCAN_UP, SCAN_DN, BLANK} mode_t;
  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_OUT - 1);
  mode_t m;
  logic [1:0] mode_q;
  logic [PRE_W-1:0] pcnt, pcnt_n;
  logic [SEL_W-1:0] idx_n;
  logic active, active_n, wrap_n, err_n, ld, sel_ok, up;
  logic [N_OUT-1:0] out_n;
  assign m = mode_t'(mode);
  assign ld = load && m != BLANK;
  assign sel_ok = {1'b0, sel} < (SEL_W+1)'(N_OUT);
  assign up = m == SCAN_UP;
  // load beats a mode change, which beats a scan step; an out-of-range load still blocks the step
  always_comb begin
    idx_n = idx;
    pcnt_n = pcnt;
    active_n = active;
    wrap_n = 1'b0;
    err_n = ld && !sel_ok;
    if (ld && sel_ok) begin
      idx_n = sel;
      active_n = 1'b1;
      pcnt_n = '0;
    end else if (mode != mode_q || m == DEC) begin
      pcnt_n = '0;
    end else if (!ld && m != BLANK) begin
      if (pcnt == prescale) begin
        pcnt_n = '0;
        active_n = 1'b1;
        idx_n = up ? (idx == LAST ? '0 : idx + 1'b1) : (idx == '0 ? LAST : idx - 1'b1);
        wrap_n = up ? idx == LAST : idx == '0;
      end else begin
        pcnt_n = pcnt + 1'b1;
      end
    end
    out_n = (active_n && m != BLANK) ? N_OUT'(1) << idx_n : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
      idx <= '0;
      wrap <= 1'b0;
      err <= 1'b0;
      pcnt <= '0;
      active <= 1'b0;
      mode_q <= 2'b00;
    end else if (en) begin
      out <= out_n;
      idx <= idx_n;
      wrap <= wrap_n;
      err <= err_n;
      pcnt <= pcnt_n;
      active <= active_n;
      mode_q <= mode;
    end else begin
      wrap <= 1'b0;
      err <= 1'b0;
    end
  end
endmodule

// File: doc/onehot_dec_seq.md
Name: onehot_dec_seq

Overview:
- Parametrised, registered binary-to-one-hot decoder; generalises the fixed 3-to-8 combinational decoder.
- Adds selectable sequencing modes: load-decode, auto-scan up, auto-scan down (programmable prescaler), and blank.
- Intended uses: register-file write enables, display digit multiplexing, and round-robin channel strobes.
- Synchronous outputs only; no combinational path from any input to `out`.

Parameters:
- SEL_W, 3, width of the binary select index.
- N_OUT, 8, number of one-hot outputs; legal range 2 .. 2**SEL_W.
- PRE_W, 16, width of the scan prescaler compare value.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  global enable; 0 freezes all state.
- mode  input  2  00 DEC, 01 SCAN_UP, 10 SCAN_DN, 11 BLANK.
- load  input  1  one-cycle strobe: capture `sel`.
- sel  input  SEL_W  binary index to decode/load.
- prescale  input  PRE_W  scan step period minus 1 (0 = advance every enabled cycle).
- out  output  N_OUT  registered one-hot (or all-zero) output.
- idx  output  SEL_W  registered current index.
- wrap  output  1  one-cycle pulse when a scan wraps.
- err  output  1  one-cycle pulse when a load has `sel` >= N_OUT.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - `out`=0, `idx`=0, `wrap`=0, `err`=0.
  - Prescaler count `pcnt`=0, `active`=0, registered previous mode `mode_q`=00.
  - Deasserting reset has no effect until the next clk edge.
- Output rule: `out` = (`active` && `mode` != BLANK) ? (1 << `idx`) : 0, registered. Latency is 1 clk from the event that changes `idx`, `active` or `mode`.
- `wrap` and `err` are single-cycle pulses. Default 0 every cycle unless set by that cycle's event.
- en=0:
  - `idx`, `pcnt`, `active` and `out` hold.
  - `wrap`=0 and `err`=0.
  - `load` is ignored (not queued).
- Mode change (`mode` != `mode_q`, en=1): `pcnt`<=0 and no advance that cycle. `mode_q` updates whenever en=1.
- Load (en=1, load=1), any mode except BLANK:
  - If `sel` < N_OUT: `idx`<=`sel`, `active`<=1, `pcnt`<=0.
  - Otherwise: `idx` and `active` unchanged, `err`<=1, `pcnt` unchanged.
  - Load has priority over a scan advance in the same cycle; no advance and no `wrap` that cycle.
- DEC: `idx` changes only on load. The prescaler is idle and held at 0.
- SCAN_UP (en=1, no load, no mode change):
  - If `pcnt` == `prescale`: `pcnt`<=0, `active`<=1, and `idx`<= (`idx` == N_OUT-1) ? 0 : `idx`+1.
  - `wrap`<=1 when stepping N_OUT-1 -> 0.
  - Otherwise `pcnt`<=`pcnt`+1.
- SCAN_DN: same as SCAN_UP, but `idx`<= (`idx` == 0) ? N_OUT-1 : `idx`-1, with `wrap`<=1 when stepping 0 -> N_OUT-1.
- First advance after reset (`active` was 0): apply the step normally from `idx`=0.
  - SCAN_UP: first visible output is bit 1.
  - SCAN_DN: first visible output is bit N_OUT-1, and `wrap` pulses.
- BLANK: `out`=0. `idx`, `pcnt` and `active` hold. `load` is ignored with no `err`.
- `prescale` changed mid-count: the new value is compared immediately.
  - If `pcnt` > new `prescale`, `pcnt` counts up, wraps modulo 2**PRE_W, then matches. This is the documented behaviour.
  - Software must load or toggle mode to resync.
- `out` is never multi-hot. `idx` is always < N_OUT.
- Non-power-of-2 N_OUT (e.g. 5 with SEL_W=3) wraps at N_OUT-1, not at 2**SEL_W-1.

Test Plan:
- Reset, then DEC, load sel=5 (defaults) -> next cycle `out`=8'b0010_0000, `idx`=5, `err`=0. Before the load, `out`=0.
- DEC, load sel=6 with N_OUT=5, SEL_W=3 -> `err` high exactly 1 cycle, `out`/`idx` unchanged.
- SCAN_UP, prescale=2, after load sel=6 -> `idx` steps 6 -> 7 -> 0 every 3 cycles; `wrap` pulses 1 cycle on 7 -> 0; `out` = 0x40, 0x80, 0x01.
- SCAN_DN, prescale=0, from idx=1 -> `out` 0x02, 0x01, 0x80 on consecutive cycles; `wrap` only on 0 -> 7.
- SCAN_UP, prescale=0, en toggled low 3 cycles mid-scan -> `out` frozen, `wrap`=0. Separately, load sel=3 in the same cycle as a pending step -> `idx`=3, no step, no `wrap`.
- Scanning, switch mode to BLANK then back to SCAN_UP -> `out`=0 during BLANK with `idx` held; first step after return occurs prescale+1 cycles after the mode change. Then assert rst_n=0 mid-scan -> `out`, `idx`, `wrap` clear immediately without a clock edge.
